dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between the pipelined processor's memory stage and one peripheral requester, such as the board/VGA reader or a host loader.
- The CPU has priority. The peripheral is served on cycles where the CPU issues no lw/sw.
- A starvation counter raises a hold request so the processor freezes and the peripheral gets one guaranteed slot.
- Sits between processor dmem outputs and the dmem instance in the wrapper.

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_starve_counter.sv | 20 ++
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encodings, default widths and the lw/sw opcodes
// the wrapper decodes into cpu_rden/cpu_wren.
package dmem_arbiter_pkg;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STARVE_LIMIT = 8;
    localparam int WAIT_CNT_W = 8;
    localparam int STAT_W = 16;
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_RD_WAIT = 2'd1;
    localparam arb_state_t ARB_FORCE = 2'd2;
    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;
endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// arb_starve_counter: saturating up-counter with synchronous clear; at_limit flags count == MAX.
module arb_starve_counter #(
    parameter int W = 8,
    parameter int MAX = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_limit
);
    logic [W-1:0] count_q, count_d;
    assign at_limit = count_q == W'(MAX);
    assign count = count_q;
    always_comb count_d = clear ? '0 : (inc && !at_limit) ? count_q + W'(1) : count_q;
    always_ff @(posedge clock or posedge reset)
        if (reset) count_q <= '0;
        else count_q <= count_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU memory stage and one peripheral,
// forcing a peripheral slot after starvation. DMEM_ARB_STATS_EN adds saturating stat counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_wren,
    input  logic              cpu_rden,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_hold,
    input  logic              per_req,
    input  logic              per_we,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
    output logic              per_gnt,
    output logic              per_rvalid,
    output logic [DATA_W-1:0] per_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
`ifdef DMEM_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_grants,
    output logic [STAT_W-1:0] stat_forced,
    output logic [STAT_W-1:0] stat_blocked,
`endif
    input  logic [DATA_W-1:0] mem_q
);
    arb_state_t state_q, state_d;
    logic rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic cpu_busy, starving, force_entry;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    assign cpu_busy = cpu_wren | cpu_rden;
    assign per_gnt = per_req & (((state_q == ARB_IDLE) & !cpu_busy) | (state_q == ARB_FORCE));
    assign starving = per_req & cpu_busy & (state_q == ARB_IDLE);
    assign force_entry = starving & (wait_cnt == WAIT_CNT_W'(STARVE_LIMIT - 1));
    assign mem_addr = per_gnt ? per_addr : cpu_addr;
    assign mem_data = per_gnt ? per_wdata : cpu_data;
    assign mem_wren = per_gnt ? per_we : cpu_wren;
    assign cpu_q = mem_q;
    assign per_rvalid = rvalid_q;
    assign per_rdata = rdata_q;
    // The wait count sits at the limit exactly while in FORCE, so it doubles as the hold flop.
    arb_starve_counter #(.W(WAIT_CNT_W), .MAX(STARVE_LIMIT)) u_wait (
        .clock(clock), .reset(reset), .clear(per_gnt | !per_req), .inc(starving),
        .count(wait_cnt), .at_limit(cpu_hold)
    );
    always_comb begin
        state_d = per_gnt ? (per_we ? ARB_IDLE : ARB_RD_WAIT) : force_entry ? ARB_FORCE : ARB_IDLE;
        rvalid_d = state_q == ARB_RD_WAIT;
        rdata_d = rvalid_d ? mem_q : rdata_q;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= ARB_IDLE;
            rvalid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q <= rdata_d;
        end
`ifdef DMEM_ARB_STATS_EN
    logic [2:0] stat_sat;
    arb_starve_counter #(.W(STAT_W), .MAX((1 << STAT_W) - 1)) u_stat_grants (
        .clock(clock), .reset(reset), .clear(1'b0), .inc(per_gnt),
        .count(stat_grants), .at_limit(stat_sat[0])
    );
    arb_starve_counter #(.W(STAT_W), .MAX((1 << STAT_W) - 1)) u_stat_forced (
        .clock(clock), .reset(reset), .clear(1'b0), .inc(per_gnt & (state_q == ARB_FORCE)),
        .count(stat_forced), .at_limit(stat_sat[1])
    );
    arb_starve_counter #(.W(STAT_W), .MAX((1 << STAT_W) - 1)) u_stat_blocked (
        .clock(clock), .reset(reset), .clear(1'b0), .inc(per_req & !per_gnt),
        .count(stat_blocked), .at_limit(stat_sat[2])
    );
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a cycle-level
// model of the sharing rules; a small RAM stands in for dmem.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LIM = 8;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [AW-1:0] cpu_addr, per_addr, mem_addr;
    logic [DW-1:0] cpu_data, cpu_q, per_wdata, per_rdata, mem_data, mem_q;
    logic cpu_wren, cpu_rden, cpu_hold, per_req, per_we, per_gnt, per_rvalid, mem_wren;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_grants, stat_forced, stat_blocked;
`endif
    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] ram [0:127];
    logic [DW-1:0] ref_mem [0:127];
    int streak, m_grants, m_forced, m_blocked;
    bit forced, pend_valid, exp_rvalid, q_known, last_gnt;
    logic [DW-1:0] pend_data, exp_rdata, exp_q;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wren(cpu_wren), .cpu_rden(cpu_rden),
        .cpu_q(cpu_q), .cpu_hold(cpu_hold),
        .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
        .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_rdata(per_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
`ifdef DMEM_ARB_STATS_EN
        .stat_grants(stat_grants), .stat_forced(stat_forced), .stat_blocked(stat_blocked),
`endif
        .mem_q(mem_q)
    );

    always @(posedge clock) begin
        mem_q <= ram[mem_addr[6:0]];
        if (reset) for (int i = 0; i < 128; i++) ram[i] <= '0;
        else if (mem_wren) ram[mem_addr[6:0]] <= mem_data;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_cpu(input bit rd, input bit wr, input int a, input logic [DW-1:0] d);
        cpu_rden = rd; cpu_wren = wr; cpu_addr = AW'(a); cpu_data = d;
    endtask

    task automatic set_per(input bit rq, input bit we, input int a, input logic [DW-1:0] d);
        per_req = rq; per_we = we; per_addr = AW'(a); per_wdata = d;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit busy, e_gnt, ew, was_pend;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, nq;
        @(negedge clock);
        busy = cpu_rden | cpu_wren;
        e_gnt = per_req && !pend_valid && (forced || !busy);
        ea = e_gnt ? per_addr : cpu_addr;
        ed = e_gnt ? per_wdata : cpu_data;
        ew = e_gnt ? per_we : cpu_wren;
        chk("per_gnt", per_gnt, e_gnt);
        chk("cpu_hold", cpu_hold, forced);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wren", mem_wren, ew);
        chk("mem_data", mem_data, ed);
        chk("per_rvalid", per_rvalid, exp_rvalid);
        chk("per_rdata", per_rdata, exp_rdata);
        if (q_known) chk("cpu_q", cpu_q, exp_q);
        m_grants += e_gnt;
        m_forced += e_gnt && forced;
        m_blocked += per_req && !e_gnt;
        nq = ref_mem[ea[6:0]];
        if (ew) ref_mem[ea[6:0]] = ed;
        was_pend = pend_valid;
        exp_rvalid = pend_valid;
        if (pend_valid) exp_rdata = pend_data;
        pend_valid = e_gnt && !per_we;
        pend_data = nq;
        if (e_gnt || !per_req) begin
            streak = 0;
            forced = 0;
        end else if (busy && !was_pend && !forced) begin
            streak++;
            if (streak >= LIM) forced = 1;
        end
        exp_q = nq;
        q_known = 1;
        last_gnt = e_gnt;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_cpu(0, 0, 0, 0);
        set_per(0, 0, 0, 0);
        reset = 1'b1;
        #2;
        chk("rst_rvalid", per_rvalid, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_rdata", per_rdata, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        streak = 0; forced = 0; pend_valid = 0; exp_rvalid = 0; exp_rdata = '0;
        q_known = 0; last_gnt = 0; m_grants = 0; m_forced = 0; m_blocked = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    endtask

    initial begin
        int n;
        do_reset();
`ifdef DMEM_ARB_STATS_EN
        for (int i = 0; i < 3; i++) begin
            set_per(1, 1, 'h50 + i, 32'(i));
            step();
        end
        set_cpu(1, 0, 'h05, 0);
        set_per(1, 1, 'h60, 'h77);
        for (int i = 0; i < LIM + 1; i++) step();
        set_cpu(0, 0, 0, 0);
        set_per(0, 0, 0, 0);
        step();
        chk("stat_grants", stat_grants, 4);
        chk("stat_forced", stat_forced, 1);
        chk("stat_blocked", stat_blocked, LIM);
        do_reset();
`endif
        // basic peripheral read with CPU idle
        set_cpu(0, 1, 'h010, 'hDEADBEEF); step();
        set_cpu(0, 0, 0, 0); set_per(1, 0, 'h010, 0); step();
        set_per(0, 0, 0, 0); step();
        chk("tp1_rdata", per_rdata, 'hDEADBEEF);
        chk("tp1_rvalid", per_rvalid, 1);
        step();
        // CPU store wins a simultaneous peripheral write
        set_cpu(0, 1, 'h020, 'h11112222); set_per(1, 1, 'h030, 'h33334444); step();
        set_cpu(0, 0, 0, 0); step();
        set_per(0, 0, 0, 0); step();
        chk("tp2_ram020", ram[7'h20], 'h11112222);
        chk("tp2_ram030", ram[7'h30], 'h33334444);
        // starvation forces a slot
        set_cpu(1, 0, 'h005, 0); set_per(1, 0, 'h020, 0);
        n = 0;
        while (!cpu_hold && n < 20) begin step(); n++; end
        chk("tp3_hold_cycles", n, LIM);
        step();
        set_per(0, 0, 0, 0);
        chk("tp3_hold_clr", cpu_hold, 0);
        step(); step();
        chk("tp3_rdata", per_rdata, 'h11112222);
        // CPU load during RD_WAIT
        set_cpu(0, 1, 'h040, 'hCAFEF00D); step();
        set_cpu(0, 0, 0, 0); set_per(1, 0, 'h010, 0); step();
        set_per(0, 0, 0, 0); set_cpu(1, 0, 'h040, 0); step();
        chk("tp4_rdata", per_rdata, 'hDEADBEEF);
        chk("tp4_cpu_q", cpu_q, 'hCAFEF00D);
        set_cpu(0, 0, 0, 0); step();
        // reset while a read is in RD_WAIT
        set_per(1, 0, 'h010, 0); step();
        do_reset();
        step();
        chk("tp5_rvalid", per_rvalid, 0);
        set_per(1, 1, 'h011, 'h5A5A5A5A); step();
        set_per(0, 0, 0, 0); step();
        // randomized traffic with phases of light, heavy and saturated CPU load
        for (int c = 0; c < 3000; c++) begin
            int phase;
            bit busy;
            phase = (c / 250) % 3;
            if ($urandom_range(0, 499) == 0) do_reset();
            busy = $urandom_range(0, 3) < 2 * phase + 1;
            cpu_rden = busy & $urandom_range(0, 1);
            cpu_wren = busy & !cpu_rden;
            cpu_addr = AW'($urandom_range(0, 31));
            cpu_data = $urandom;
            if (last_gnt || !per_req) begin
                per_req = $urandom_range(0, 2) != 0;
                per_we = $urandom_range(0, 1);
                per_addr = AW'($urandom_range(0, 31));
                per_wdata = $urandom;
            end else if ($urandom_range(0, 99) == 0) per_req = 0;
            step();
        end
`ifdef DMEM_ARB_STATS_EN
        chk("rand_grants", stat_grants, m_grants);
        chk("rand_forced", stat_forced, m_forced);
        chk("rand_blocked", stat_blocked, m_blocked);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
